// File: rtl/fast_arc_scorer_pkg.sv
// Shared definitions for the FAST arc scorer: FSM states, ring geometry
// and the width helpers used to size ports.
package fast_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ARC,
        ST_WRITE
    } state_t;

    localparam int RING_N = 16;

    // Bresenham radius-3 circle, clockwise starting at the top pixel.
    localparam int OFF_X [RING_N] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int OFF_Y [RING_N] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    // Signed coordinate width: one extra bit holds the sign.
    function automatic int calc_aw(input int x_max);
        return $clog2(x_max) + 1;
    endfunction

    // Four extra bits so a sum of sixteen pixel differences never wraps.
    function automatic int calc_score_w(input int pix_w);
        return pix_w + 4;
    endfunction

endpackage

// File: rtl/fast_arc_scorer_if.sv
// SRAM-side bus of the arc scorer: Gaussian read port and FAST write port.
interface fast_arc_scorer_if #(
    parameter int AW      = 4,
    parameter int PIX_W   = 8,
    parameter int SCORE_W = 12
);
    logic                 read_SRAM_gaus;
    logic signed [AW-1:0] x_addr_gaus;
    logic signed [AW-1:0] y_addr_gaus;
    logic [PIX_W-1:0]     SRAM_in_gaus;
    logic                 write_SRAM_fast;
    logic signed [AW-1:0] x_addr_fast;
    logic signed [AW-1:0] y_addr_fast;
    logic [SCORE_W-1:0]   fast_wdata;

    modport master (
        output read_SRAM_gaus, x_addr_gaus, y_addr_gaus,
        output write_SRAM_fast, x_addr_fast, y_addr_fast, fast_wdata,
        input  SRAM_in_gaus
    );

    modport slave (
        input  read_SRAM_gaus, x_addr_gaus, y_addr_gaus,
        input  write_SRAM_fast, x_addr_fast, y_addr_fast, fast_wdata,
        output SRAM_in_gaus
    );
endinterface

// File: rtl/fast_arc_scorer_detect.sv
// Combinational contiguous-arc detector over the 16-pixel ring mask,
// wrapping around from index 15 back to index 0.
module fast_arc_detect
    import fast_pkg::*;
#(
    parameter int ARC_LEN = 9
) (
    input  logic [RING_N-1:0] mask,
    output logic              hit
);
    // Mask extended by its low bits so every wrapped window is a plain slice.
    logic [RING_N+ARC_LEN-2:0] twice;

    // Test a window of ARC_LEN set bits at each of the 16 start positions.
    always_comb begin
        twice = {mask[ARC_LEN-2:0], mask};
        hit   = 1'b0;
        for (int s = 0; s < RING_N; s++) begin
            hit = hit | (&twice[s +: ARC_LEN]);
        end
    end
endmodule

// File: rtl/fast_arc_scorer.sv
// FAST-N segment test and scorer for one candidate pixel: fetches the centre
// and the 16-pixel ring, classifies against a runtime threshold, detects an
// ARC_LEN arc and writes a graded score (0 for non-corners).
module fast_arc_scorer
    import fast_pkg::*;
#(
    parameter int  X_MAX   = 5,
    parameter int  Y_MAX   = 5,
    parameter int  PIX_W   = 8,
    parameter int  ARC_LEN = 9,
    parameter int  SCORE_W = calc_score_w(PIX_W),
    localparam int AW      = calc_aw(X_MAX)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic signed [AW-1:0] center_x,
    input  logic signed [AW-1:0] center_y,
    input  logic signed [AW-1:0] max_x,
    input  logic signed [AW-1:0] max_y,
    input  logic [PIX_W-1:0]     threshold,
    fast_arc_scorer_if.master    bus,
    output logic                 is_corner,
    output logic                 busy,
    output logic                 update_sample
);
    // Ring addresses are formed two bits wider so centre +/- 3 never wraps.
    localparam int EW = AW + 2;

    if (ARC_LEN < 9 || ARC_LEN > 12) begin : g_bad_arc_len
        $error("fast_arc_scorer: ARC_LEN must lie in 9..12");
    end
    if (Y_MAX > (1 << (AW - 1))) begin : g_bad_y_max
        $error("fast_arc_scorer: Y_MAX does not fit the signed address width");
    end

    state_t                  state, state_nxt;
    logic [4:0]              slot;
    logic signed [AW-1:0]    cx, cy, mx, my;
    logic [PIX_W-1:0]        thr, cpix;
    logic [4:0]              slot_p0;
    logic                    rd_p0, vld_p0;
    logic [3:0]              ring_idx, ring_p0;
    logic signed [EW-1:0]    rx, ry;
    logic                    in_bounds, rd;
    logic signed [PIX_W+1:0] p_s, c_s, t_s, diff_b, diff_d;
    logic                    is_b, is_d;
    logic [RING_N-1:0]       bright, dark;
    logic [SCORE_W-1:0]      sum_b, sum_d, score;
    logic                    corner, hit_b, hit_d;

    function automatic logic [SCORE_W-1:0] acc(input logic [SCORE_W-1:0] sum,
                                               input logic signed [PIX_W+1:0] d);
        return sum + SCORE_W'(unsigned'(d));
    endfunction

    function automatic logic [SCORE_W-1:0] arc_score(input logic hit,
                                                     input logic [SCORE_W-1:0] sb,
                                                     input logic [SCORE_W-1:0] sd);
        if (!hit) return '0;
        return (sb > sd) ? sb : sd;
    endfunction

    fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_det_bright (.mask(bright), .hit(hit_b));
    fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_det_dark   (.mask(dark),   .hit(hit_d));

    // State register and FETCH slot counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            slot  <= (state == ST_FETCH) ? slot + 5'd1 : 5'd0;
        end
    end

    // Next-state decode and control outputs.
    always_comb begin
        state_nxt           = state;
        busy                = 1'b0;
        update_sample       = 1'b0;
        bus.write_SRAM_fast = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                busy = 1'b1;
                if (slot == 5'(RING_N)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                state_nxt = ST_ARC;
            end
            ST_ARC: begin
                busy      = 1'b1;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy                = 1'b1;
                update_sample       = 1'b1;
                bus.write_SRAM_fast = 1'b1;
                state_nxt           = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Read address for the current slot; out-of-image ring pixels are not read.
    always_comb begin
        ring_idx = 4'(slot - 5'd1);
        rx       = EW'(cx);
        ry       = EW'(cy);
        if (slot != 5'd0) begin
            rx = EW'(cx) + EW'(OFF_X[ring_idx]);
            ry = EW'(cy) + EW'(OFF_Y[ring_idx]);
        end
        in_bounds = !rx[EW-1] && !ry[EW-1] && (rx <= EW'(mx)) && (ry <= EW'(my));
        rd        = (state == ST_FETCH) && in_bounds;
        bus.read_SRAM_gaus = rd;
        bus.x_addr_gaus    = rd ? AW'(rx) : '0;
        bus.y_addr_gaus    = rd ? AW'(ry) : '0;
    end

    // Classify the pixel returned for the previous slot.
    always_comb begin
        p_s    = signed'({2'b00, bus.SRAM_in_gaus});
        c_s    = signed'({2'b00, cpix});
        t_s    = signed'({2'b00, thr});
        diff_b = p_s - c_s - t_s;
        diff_d = c_s - p_s - t_s;
        is_b   = rd_p0 && !diff_b[PIX_W+1] && (diff_b != '0);
        is_d   = rd_p0 && !diff_d[PIX_W+1] && (diff_d != '0);
    end

    assign ring_p0 = 4'(slot_p0 - 5'd1);

    // Request latch, read-return pipeline, classification masks and score.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cx      <= '0;
            cy      <= '0;
            mx      <= '0;
            my      <= '0;
            thr     <= '0;
            cpix    <= '0;
            slot_p0 <= '0;
            rd_p0   <= 1'b0;
            vld_p0  <= 1'b0;
            bright  <= '0;
            dark    <= '0;
            sum_b   <= '0;
            sum_d   <= '0;
            score   <= '0;
            corner  <= 1'b0;
        end else begin
            // p0: slot issued this cycle, its data returns next cycle
            vld_p0  <= (state == ST_FETCH);
            slot_p0 <= slot;
            rd_p0   <= rd;
            if (state == ST_IDLE && start) begin
                cx     <= center_x;
                cy     <= center_y;
                mx     <= max_x;
                my     <= max_y;
                thr    <= threshold;
                bright <= '0;
                dark   <= '0;
                sum_b  <= '0;
                sum_d  <= '0;
            end
            if (vld_p0) begin
                if (slot_p0 == 5'd0) begin
                    cpix <= bus.SRAM_in_gaus;
                end else begin
                    bright[ring_p0] <= is_b;
                    dark[ring_p0]   <= is_d;
                    if (is_b) sum_b <= acc(sum_b, diff_b);
                    if (is_d) sum_d <= acc(sum_d, diff_d);
                end
            end
            if (state == ST_ARC) begin
                corner <= hit_b | hit_d;
                score  <= arc_score(hit_b | hit_d, sum_b, sum_d);
            end
        end
    end

    assign bus.x_addr_fast = cx;
    assign bus.y_addr_fast = cy;
    assign bus.fast_wdata  = score;
    assign is_corner       = corner;

endmodule

// File: tb/tb_fast_arc_scorer.sv
// Scoreboard bench for fast_arc_scorer: two instances (ARC_LEN 9 and 12)
// share the stimulus; a monitor checks every FAST write against queued
// expectations, plus reset values, read counts and out-of-image reads.
`timescale 1ns/1ps
module tb_fast_arc_scorer;
    localparam int AW      = 4;
    localparam int PIX_W   = 8;
    localparam int SCORE_W = 12;
    localparam int RX [16] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int RY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    typedef struct {
        int x;
        int y;
        int data;
        int corner;
        int reads;
        int due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [AW-1:0] center_x = '0;
    logic signed [AW-1:0] center_y = '0;
    logic signed [AW-1:0] max_x = 4'sd6;
    logic signed [AW-1:0] max_y = 4'sd6;
    logic [PIX_W-1:0]     threshold = '0;
    logic                 is_corner9, busy9, upd9;
    logic                 is_corner12, busy12, upd12;

    logic [7:0] img [0:6][0:6];
    exp_t       q0[$];
    exp_t       q1[$];
    int         rd_cnt [2];
    int         bad [2];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    fast_arc_scorer_if #(.AW(AW), .PIX_W(PIX_W), .SCORE_W(SCORE_W)) bus9 ();
    fast_arc_scorer_if #(.AW(AW), .PIX_W(PIX_W), .SCORE_W(SCORE_W)) bus12 ();

    fast_arc_scorer #(.X_MAX(5), .Y_MAX(5), .PIX_W(PIX_W), .ARC_LEN(9), .SCORE_W(SCORE_W)) dut9 (
        .clk(clk), .n_rst(n_rst), .start(start),
        .center_x(center_x), .center_y(center_y), .max_x(max_x), .max_y(max_y),
        .threshold(threshold), .bus(bus9),
        .is_corner(is_corner9), .busy(busy9), .update_sample(upd9)
    );

    fast_arc_scorer #(.X_MAX(5), .Y_MAX(5), .PIX_W(PIX_W), .ARC_LEN(12), .SCORE_W(SCORE_W)) dut12 (
        .clk(clk), .n_rst(n_rst), .start(start),
        .center_x(center_x), .center_y(center_y), .max_x(max_x), .max_y(max_y),
        .threshold(threshold), .bus(bus12),
        .is_corner(is_corner12), .busy(busy12), .update_sample(upd12)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix_at(input int x, input int y);
        if (x < 0 || y < 0 || x > 6 || y > 6) return 8'h00;
        return img[y][x];
    endfunction

    // Gaussian SRAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (bus9.read_SRAM_gaus)
            bus9.SRAM_in_gaus <= pix_at(int'(bus9.x_addr_gaus), int'(bus9.y_addr_gaus));
        if (bus12.read_SRAM_gaus)
            bus12.SRAM_in_gaus <= pix_at(int'(bus12.x_addr_gaus), int'(bus12.y_addr_gaus));
    end

    task automatic check(input int id, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d, want %0d", id, name, act, exp);
        end
    endtask

    task automatic take(input int id, output exp_t e);
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
    endtask

    task automatic observe(input int id, input logic rd,
                           input logic signed [AW-1:0] xg, input logic signed [AW-1:0] yg,
                           input logic wr,
                           input logic signed [AW-1:0] xf, input logic signed [AW-1:0] yf,
                           input logic [SCORE_W-1:0] wd,
                           input logic cor, input logic upd, input logic bsy);
        exp_t e;
        int   qs;
        qs = (id == 0) ? q0.size() : q1.size();
        if (!n_rst) begin
            check(id, "reset_ctrl", int'({rd, wr, cor, upd, bsy}), 0);
            check(id, "reset_addr", int'({xg, yg, xf, yf}), 0);
            check(id, "reset_wdata", int'(wd), 0);
            rd_cnt[id] = 0;
            bad[id]    = 0;
        end else begin
            if (rd) begin
                rd_cnt[id]++;
                if (xg < 0 || yg < 0 || xg > 6 || yg > 6) bad[id] = 1;
            end
            if (wr) begin
                if (qs == 0) begin
                    check(id, "unexpected_write", int'(wr), 0);
                end else begin
                    take(id, e);
                    check(id, "addr_x", int'(xf), e.x);
                    check(id, "addr_y", int'(yf), e.y);
                    check(id, "score", int'(wd), e.data);
                    check(id, "is_corner", int'(cor), e.corner);
                    check(id, "latency", cyc, e.due);
                    check(id, "update_sample", int'(upd), 1);
                    check(id, "busy", int'(bsy), 1);
                    check(id, "read_count", rd_cnt[id], e.reads);
                    check(id, "oob_read", bad[id], 0);
                end
                rd_cnt[id] = 0;
                bad[id]    = 0;
            end else if (qs > 0) begin
                e = (id == 0) ? q0[0] : q1[0];
                if (cyc > e.due) begin
                    check(id, "write_timeout", int'(wr), 1);
                    take(id, e);
                end
            end
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard away from the edge.
    always @(negedge clk) begin
        observe(0, bus9.read_SRAM_gaus, bus9.x_addr_gaus, bus9.y_addr_gaus,
                bus9.write_SRAM_fast, bus9.x_addr_fast, bus9.y_addr_fast,
                bus9.fast_wdata, is_corner9, upd9, busy9);
        observe(1, bus12.read_SRAM_gaus, bus12.x_addr_gaus, bus12.y_addr_gaus,
                bus12.write_SRAM_fast, bus12.x_addr_fast, bus12.y_addr_fast,
                bus12.fast_wdata, is_corner12, upd12, busy12);
    end

    task automatic fill(input int v);
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++)
                img[y][x] = 8'(v);
    endtask

    task automatic set_ring(input int cx, input int cy, input int idx, input int v);
        img[cy + RY[idx]][cx + RX[idx]] = 8'(v);
    endtask

    task automatic run_op(input int x, input int y, input int t,
                          input int d9, input int c9, input int d12, input int c12,
                          input int reads, input int glitch);
        @(negedge clk);
        center_x  = AW'(x);
        center_y  = AW'(y);
        threshold = PIX_W'(t);
        start     = 1'b1;
        q0.push_back('{x, y, d9, c9, reads, cyc + 20});
        q1.push_back('{x, y, d12, c12, reads, cyc + 20});
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 24; i++) begin
            if (i == glitch) begin
                start     = 1'b1;
                center_x  = 4'sd1;
                center_y  = 4'sd1;
                threshold = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;

        // Flat image: no corner, score 0.
        fill(100);
        run_op(3, 3, 20, 0, 0, 0, 0, 17, 0);

        // Bright arc on indices 0..8: corner for ARC_LEN 9 only.
        fill(100);
        for (int i = 0; i <= 8; i++) set_ring(3, 3, i, 150);
        run_op(3, 3, 20, 270, 1, 0, 0, 17, 0);

        // Dark arc wrapping 12..15,0..4.
        fill(100);
        for (int i = 12; i <= 15; i++) set_ring(3, 3, i, 40);
        for (int i = 0; i <= 4; i++) set_ring(3, 3, i, 40);
        run_op(3, 3, 20, 360, 1, 0, 0, 17, 0);

        // Twelve-pixel bright arc 2..13: corner for both arc lengths.
        fill(100);
        for (int i = 2; i <= 13; i++) set_ring(3, 3, i, 160);
        run_op(3, 3, 20, 480, 1, 480, 1, 17, 0);

        // Border candidate (0,0): only the centre and indices 4..8 are read.
        fill(100);
        for (int i = 4; i <= 8; i++) set_ring(0, 0, i, 200);
        run_op(0, 0, 20, 0, 0, 0, 0, 6, 0);

        // Large values and threshold: nothing classifies; stray start ignored.
        fill(255);
        img[3][3] = 8'd250;
        run_op(3, 3, 255, 0, 0, 0, 0, 17, 8);

        // Zero threshold: every differing pixel is bright.
        fill(101);
        img[3][3] = 8'd100;
        run_op(3, 3, 0, 16, 1, 16, 1, 17, 0);

        // Reset mid-operation: no write may follow.
        fill(100);
        for (int i = 0; i <= 8; i++) set_ring(3, 3, i, 150);
        @(negedge clk);
        center_x  = 4'sd3;
        center_y  = 4'sd3;
        threshold = 8'd20;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Normal operation after reset release.
        run_op(3, 3, 20, 270, 1, 0, 0, 17, 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
